// File: rtl/spike_tx_pkg.sv
// Shared definitions for spike_frame_tx: FSM encoding, sentinel address and
// bitmap sizing helpers.
package spike_tx_pkg;

   typedef enum logic [1:0] {StIdle, StScan, StFlush, StDone} tx_state_e;

   // Truncated to the address width at the point of use.
   localparam logic [31:0] SENTINEL_ADDR = 32'hFFFF_FFFF;

   function automatic int unsigned num_words_f(input int unsigned num_inputs,
                                               input int unsigned word_width);
      return (num_inputs + word_width - 1) / word_width;
   endfunction

   function automatic int unsigned waddr_width_f(input int unsigned num_inputs,
                                                 input int unsigned word_width);
      int unsigned nw;
      nw = num_words_f(num_inputs, word_width);
      return (nw > 1) ? $clog2(nw) : 1;
   endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Lowest-set-bit priority encoder: index of the lowest set bit, an any-set flag,
// and the input word with that bit cleared.
module lsb_priority_enc #(
   parameter int unsigned WORD_WIDTH = 32,
   parameter int unsigned IDX_WIDTH  = $clog2(WORD_WIDTH)
) (
   input  logic [WORD_WIDTH-1:0] i_word,
   output logic [IDX_WIDTH-1:0]  o_idx,
   output logic                  o_any,
   output logic [WORD_WIDTH-1:0] o_cleared
);

   always_comb begin
      o_idx = '0;
      // Scanning downwards leaves the lowest set position as the final assignment.
      for (int i = WORD_WIDTH - 1; i >= 0; i--) begin
         if (i_word[i]) o_idx = IDX_WIDTH'(i);
      end
      o_any     = |i_word;
      o_cleared = i_word & (i_word - WORD_WIDTH'(1));
   end

endmodule

// File: rtl/spike_frame_tx.sv
// Spike frame transmitter: accumulates a spike bitmap, then streams set-bit addresses
// in ascending order. Define SPIKE_TX_EMPTY_BEAT_EN to emit a sentinel beat for empty frames.
module spike_frame_tx
   import spike_tx_pkg::*;
#(
   parameter int unsigned NUM_INPUTS  = 10000,
   parameter int unsigned ADDR_WIDTH  = 14,
   parameter int unsigned WORD_WIDTH  = 32,
   parameter int unsigned NUM_WORDS   = num_words_f(NUM_INPUTS, WORD_WIDTH),
   parameter int unsigned WADDR_WIDTH = waddr_width_f(NUM_INPUTS, WORD_WIDTH)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_bm_wr_en,
   input  logic [WADDR_WIDTH-1:0] i_bm_wr_addr,
   input  logic [WORD_WIDTH-1:0]  i_bm_wr_data,
   input  logic                   i_frame_start,
   output logic                   o_busy,
   output logic                   o_wr_drop,
   output logic                   o_spike_tvalid,
   input  logic                   i_spike_tready,
   output logic [ADDR_WIDTH-1:0]  o_spike_tdata,
   output logic                   o_spike_tlast,
   output logic                   o_frame_done,
   output logic [ADDR_WIDTH:0]    o_spike_count
);

   localparam int unsigned BIT_WIDTH = $clog2(WORD_WIDTH);
   localparam int unsigned LAST_BITS = NUM_INPUTS - (NUM_WORDS - 1) * WORD_WIDTH;
   localparam logic [WADDR_WIDTH-1:0] LAST_WORD = WADDR_WIDTH'(NUM_WORDS - 1);

   tx_state_e r_state, w_state_next;

   logic [WORD_WIDTH-1:0]  r_mem [NUM_WORDS];
   logic [WORD_WIDTH-1:0]  r_scan_word;
   logic [WADDR_WIDTH-1:0] r_word_idx;
   logic                   r_pend_valid;
   logic [ADDR_WIDTH-1:0]  r_pend_addr;
   logic                   r_out_valid;
   logic                   r_out_last;
   logic [ADDR_WIDTH-1:0]  r_out_data;
   logic [ADDR_WIDTH:0]    r_count;
   logic                   r_wr_drop;
   logic                   r_frame_done;

   logic                   w_idle, w_wr_ok, w_start, w_accept, w_slot_free, w_room;
   logic                   w_extract, w_advance, w_scan_end, w_flush_pend, w_flush_empty;
   logic                   w_done_go;
   logic [WORD_WIDTH-1:0]  w_wr_word, w_next_word, w_start_word, w_cleared;
   logic [WADDR_WIDTH-1:0] w_next_idx;
   logic [BIT_WIDTH-1:0]   w_bit_idx;
   logic                   w_any;
   logic [ADDR_WIDTH-1:0]  w_new_addr;

   lsb_priority_enc #(
      .WORD_WIDTH (WORD_WIDTH),
      .IDX_WIDTH  (BIT_WIDTH)
   ) u_enc (
      .i_word    (r_scan_word),
      .o_idx     (w_bit_idx),
      .o_any     (w_any),
      .o_cleared (w_cleared)
   );

   // Bits beyond NUM_INPUTS in the last word never enter the bitmap.
   always_comb begin
      w_wr_word = i_bm_wr_data;
      if (i_bm_wr_addr == LAST_WORD) begin
         for (int b = 0; b < WORD_WIDTH; b++) begin
            if (b >= LAST_BITS) w_wr_word[b] = 1'b0;
         end
      end
   end

   always_comb begin
      w_next_word = '0;
      for (int i = 0; i < NUM_WORDS; i++) begin
         if (w_next_idx == WADDR_WIDTH'(i)) w_next_word = r_mem[i];
      end
   end

   always_comb begin
      w_idle        = (r_state == StIdle);
      w_wr_ok       = i_bm_wr_en && w_idle && (32'(i_bm_wr_addr) < NUM_WORDS);
      w_start       = w_idle && i_frame_start;
      w_accept      = r_out_valid && i_spike_tready;
      w_slot_free   = !r_out_valid || i_spike_tready;
      w_room        = !r_pend_valid || w_slot_free;
      w_next_idx    = r_word_idx + WADDR_WIDTH'(1);
      w_extract     = (r_state == StScan) && w_any && w_room;
      w_advance     = (r_state == StScan) && !w_any && (r_word_idx != LAST_WORD);
      w_scan_end    = (r_state == StScan) && !w_any && (r_word_idx == LAST_WORD);
      w_flush_pend  = (r_state == StFlush) && r_pend_valid && w_slot_free;
      w_flush_empty = (r_state == StFlush) && !r_pend_valid;
      w_done_go     = (r_state == StDone) && (w_accept || !r_out_valid);
      w_new_addr    = ADDR_WIDTH'(32'(r_word_idx) * WORD_WIDTH + 32'(w_bit_idx));
      // A same-cycle write to word 0 is folded into the first scan word.
      w_start_word  = r_mem[0] |
                      ((w_wr_ok && (i_bm_wr_addr == '0)) ? w_wr_word : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= StIdle;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_frame_start) w_state_next = StScan;
         StScan:  if (w_scan_end) w_state_next = StFlush;
         StFlush: if (w_flush_pend || w_flush_empty) w_state_next = StDone;
         StDone:  if (w_done_go) w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_busy         = !w_idle;
      o_wr_drop      = r_wr_drop;
      o_spike_tvalid = r_out_valid;
      o_spike_tdata  = r_out_data;
      o_spike_tlast  = r_out_last;
      o_frame_done   = r_frame_done;
      o_spike_count  = r_count;
   end

   // Words are cleared as they are loaded into the scan register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) r_mem[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            if ((w_start && i == 0) || (w_advance && w_next_idx == WADDR_WIDTH'(i))) begin
               r_mem[i] <= '0;
            end else if (w_wr_ok && i_bm_wr_addr == WADDR_WIDTH'(i)) begin
               r_mem[i] <= r_mem[i] | w_wr_word;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_scan_word  <= '0;
         r_word_idx   <= '0;
         r_pend_valid <= 1'b0;
         r_pend_addr  <= '0;
         r_out_valid  <= 1'b0;
         r_out_last   <= 1'b0;
         r_out_data   <= '0;
         r_count      <= '0;
         r_wr_drop    <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         if (w_start) begin
            r_scan_word <= w_start_word;
            r_word_idx  <= '0;
         end else if (w_extract) begin
            r_scan_word <= w_cleared;
         end else if (w_advance) begin
            r_scan_word <= w_next_word;
            r_word_idx  <= w_next_idx;
         end

         if (w_extract) begin
            r_pend_valid <= 1'b1;
            r_pend_addr  <= w_new_addr;
         end else if (w_flush_pend) begin
            r_pend_valid <= 1'b0;
         end

         if (w_extract && r_pend_valid) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_pend_addr;
            r_out_last  <= 1'b0;
         end else if (w_flush_pend) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_pend_addr;
            r_out_last  <= 1'b1;
`ifdef SPIKE_TX_EMPTY_BEAT_EN
         end else if (w_flush_empty) begin
            r_out_valid <= 1'b1;
            r_out_data  <= SENTINEL_ADDR[ADDR_WIDTH-1:0];
            r_out_last  <= 1'b1;
`endif
         end else if (w_accept) begin
            r_out_valid <= 1'b0;
         end

         if (w_start)       r_count <= '0;
         else if (w_accept) r_count <= r_count + 1'b1;

         r_wr_drop    <= i_bm_wr_en && !w_idle;
         r_frame_done <= w_done_go;
      end
   end

endmodule

// File: tb/tb_spike_frame_tx.sv
// Scoreboard bench for spike_frame_tx with a 100-input, 4-word bitmap: stimulus pushes
// expected beats and done counts, a negedge monitor pops and compares them.
module tb_spike_frame_tx;

   localparam int unsigned NI = 100;
   localparam int unsigned AW = 14;
   localparam int unsigned WW = 32;
   localparam int unsigned NW = 4;
   localparam int unsigned WAW = 2;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           i_bm_wr_en = 1'b0;
   logic [WAW-1:0] i_bm_wr_addr = '0;
   logic [WW-1:0]  i_bm_wr_data = '0;
   logic           i_frame_start = 1'b0;
   logic           o_busy, o_wr_drop, o_spike_tvalid, o_spike_tlast, o_frame_done;
   logic           i_spike_tready = 1'b1;
   logic [AW-1:0]  o_spike_tdata;
   logic [AW:0]    o_spike_count;

   int n_vec = 0;
   int n_err = 0;
   int n_done = 0;
   logic [AW:0] exp_q[$];
   logic [AW:0] done_q[$];
   logic        stall = 1'b0;
   logic [AW:0] hold_beat = '0;

   spike_frame_tx #(
      .NUM_INPUTS (NI),
      .ADDR_WIDTH (AW),
      .WORD_WIDTH (WW)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_bm_wr_en     (i_bm_wr_en),
      .i_bm_wr_addr   (i_bm_wr_addr),
      .i_bm_wr_data   (i_bm_wr_data),
      .i_frame_start  (i_frame_start),
      .o_busy         (o_busy),
      .o_wr_drop      (o_wr_drop),
      .o_spike_tvalid (o_spike_tvalid),
      .i_spike_tready (i_spike_tready),
      .o_spike_tdata  (o_spike_tdata),
      .o_spike_tlast  (o_spike_tlast),
      .o_frame_done   (o_frame_done),
      .o_spike_count  (o_spike_count)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input logic [31:0] act,
                                 input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   // Monitor: beats and done pulses are matched against the queues.
   always @(negedge clk) begin
      if (!rst_n) begin
         stall = 1'b0;
      end else begin
         if (stall) begin
            check("stall_tvalid_held", 32'(o_spike_tvalid), 32'd1);
            check("stall_beat_held", 32'({o_spike_tlast, o_spike_tdata}), 32'(hold_beat));
         end
         if (o_spike_tvalid && i_spike_tready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 32'({o_spike_tlast, o_spike_tdata}), 32'hDEAD_BEEF);
            end else begin
               check("beat_last_data", 32'({o_spike_tlast, o_spike_tdata}),
                     32'(exp_q.pop_front()));
            end
         end
         stall     = o_spike_tvalid && !i_spike_tready;
         hold_beat = {o_spike_tlast, o_spike_tdata};
         if (o_frame_done) begin
            n_done++;
            if (done_q.size() == 0) begin
               check("unexpected_done", 32'(o_spike_count), 32'hDEAD_BEEF);
            end else begin
               check("done_count", 32'(o_spike_count), 32'(done_q.pop_front()));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [WAW-1:0] addr, input logic [WW-1:0] data);
      i_bm_wr_en   = 1'b1;
      i_bm_wr_addr = addr;
      i_bm_wr_data = data;
      tick();
      i_bm_wr_en   = 1'b0;
   endtask

   task automatic beat(input int unsigned addr, input bit last);
      exp_q.push_back({last, AW'(addr)});
   endtask

   task automatic expect_empty_frame();
`ifdef SPIKE_TX_EMPTY_BEAT_EN
      exp_q.push_back({1'b1, 14'h3FFF});
      done_q.push_back(15'd1);
`else
      done_q.push_back(15'd0);
`endif
   endtask

   // Waits for the done pulse within budget cycles; optionally toggles tready 1,0,0,1.
   task automatic wait_done(input string name, input int budget, input bit toggle);
      int base;
      int c;
      base = n_done;
      c = 0;
      while (n_done == base && c < budget) begin
         if (toggle) i_spike_tready = ((c % 4) == 0) || ((c % 4) == 3);
         tick();
         c++;
      end
      i_spike_tready = 1'b1;
      check(name, 32'(n_done - base), 32'd1);
      check({name, "_idle"}, 32'(o_busy), 32'd0);
   endtask

   task automatic run_frame(input string name, input int budget, input bit toggle);
      i_frame_start = 1'b1;
      tick();
      i_frame_start = 1'b0;
      wait_done(name, budget, toggle);
   endtask

   initial begin
      int c;
      #1;
      check("rst_tvalid", 32'(o_spike_tvalid), 32'd0);
      check("rst_busy", 32'(o_busy), 32'd0);
      check("rst_done", 32'(o_frame_done), 32'd0);
      check("rst_count", 32'(o_spike_count), 32'd0);
      check("rst_wr_drop", 32'(o_wr_drop), 32'd0);
      check("rst_tdata_tlast", 32'({o_spike_tlast, o_spike_tdata}), 32'd0);
      repeat (3) tick();
      rst_n = 1'b1;
      tick();

      // Basic frame: addresses 0, 2, 95.
      wr(2'd0, 32'h0000_0005);
      wr(2'd2, 32'h8000_0000);
      beat(0, 0); beat(2, 0); beat(95, 1);
      done_q.push_back(15'd3);
      run_frame("frame_basic", NW + 3 + 5, 1'b0);

      // Bitmap self-cleared, so this frame is empty.
      expect_empty_frame();
      run_frame("frame_empty_after_scan", NW + 5 + 1, 1'b0);

      // Last word masked beyond address 99.
      wr(2'd3, 32'hFFFF_FFFF);
      beat(96, 0); beat(97, 0); beat(98, 0); beat(99, 1);
      done_q.push_back(15'd4);
      run_frame("frame_masked", NW + 4 + 5, 1'b0);

      // Backpressure with tready 1,0,0,1,...
      wr(2'd1, 32'h0000_0011);
      wr(2'd3, 32'h0000_0004);
      beat(32, 0); beat(36, 0); beat(98, 1);
      done_q.push_back(15'd3);
      run_frame("frame_stall", 40, 1'b1);

      // Write and start in the same cycle, then a dropped write and ignored start.
      beat(32, 1);
      done_q.push_back(15'd1);
      i_bm_wr_en    = 1'b1;
      i_bm_wr_addr  = 2'd1;
      i_bm_wr_data  = 32'h0000_0001;
      i_frame_start = 1'b1;
      tick();
      i_bm_wr_addr  = 2'd2;
      tick();
      i_bm_wr_en    = 1'b0;
      i_frame_start = 1'b0;
      check("wr_drop_pulse", 32'(o_wr_drop), 32'd1);
      check("busy_during_frame", 32'(o_busy), 32'd1);
      tick();
      check("wr_drop_one_cycle", 32'(o_wr_drop), 32'd0);
      wait_done("frame_same_cycle_wr", NW + 1 + 5, 1'b0);

      expect_empty_frame();
      run_frame("frame_drop_absent", NW + 5 + 1, 1'b0);

      // Reset mid-frame with a stalled beat on the bus.
      wr(2'd0, 32'h0000_0003);
      wr(2'd3, 32'h0000_0001);
      i_spike_tready = 1'b0;
      i_frame_start  = 1'b1;
      tick();
      i_frame_start  = 1'b0;
      c = 0;
      while (!o_spike_tvalid && c < 10) begin
         tick();
         c++;
      end
      check("tvalid_before_reset", 32'(o_spike_tvalid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("reset_drops_tvalid", 32'(o_spike_tvalid), 32'd0);
      check("reset_busy", 32'(o_busy), 32'd0);
      check("reset_count", 32'(o_spike_count), 32'd0);
      exp_q.delete();
      done_q.delete();
      tick();
      rst_n = 1'b1;
      i_spike_tready = 1'b1;
      tick();
      expect_empty_frame();
      run_frame("frame_after_reset", NW + 5 + 1, 1'b0);

      repeat (3) tick();
      check("beats_drained", 32'(exp_q.size()), 32'd0);
      check("dones_drained", 32'(done_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spike_frame_tx.md
Name: spike_frame_tx

Overview:
- Transmit end of the spike-address stream. Holds one frame of input spikes as a bitmap. On command, scans the bitmap and emits each set bit's address on the AXI4-Stream-like spike interface (tvalid/tready/tdata/tlast).
- Sits upstream of the source-neuron system and feeds its spike FIFO. Asserts tlast on the final address of the frame, which triggers downstream processing.

Parameters:
- NUM_INPUTS, 10000, number of spike sources (bitmap bits).
- ADDR_WIDTH, 14, spike address width, log2ceil(NUM_INPUTS).
- WORD_WIDTH, 32, bitmap word width; must be a power of 2.
- NUM_WORDS, ceil(NUM_INPUTS/WORD_WIDTH) (313), bitmap depth; derived.
- WADDR_WIDTH, 9, word address width, log2ceil(NUM_WORDS).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- i_bm_wr_en  in  1  bitmap word write strobe.
- i_bm_wr_addr  in  WADDR_WIDTH  word index to write.
- i_bm_wr_data  in  WORD_WIDTH  spike bits; OR-merged into the stored word.
- i_frame_start  in  1  start scanning/transmitting the current frame.
- o_busy  out  1  high from the accepted start until o_frame_done.
- o_wr_drop  out  1  one-cycle pulse: a write was ignored because o_busy was high.
- o_spike_tvalid  out  1  beat valid.
- i_spike_tready  in  1  downstream ready.
- o_spike_tdata  out  ADDR_WIDTH  spike address = word_idx*WORD_WIDTH + bit.
- o_spike_tlast  out  1  last beat of the frame.
- o_frame_done  out  1  one-cycle pulse after the tlast beat is accepted (or after an empty frame).
- o_spike_count  out  ADDR_WIDTH+1  beats accepted in the current/last frame.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset: all outputs 0; FSM in IDLE; bitmap, pending and output registers cleared.
- Writes, IDLE only:
  - mem[addr] |= data.
  - Bits at addresses >= NUM_INPUTS in the last word are masked to 0 on write.
  - Out-of-range word addresses are ignored.
  - Write while busy: dropped, o_wr_drop pulses.
- Start: i_frame_start in IDLE is accepted. A write in the same cycle lands first and is part of the frame. Start while busy is ignored.
- FSM states: IDLE -> SCAN -> FLUSH -> DONE -> IDLE.
- SCAN: scan_word holds the current word; word_idx starts at 0. Each cycle:
  - If scan_word != 0 and there is room (pending empty, or the output slot is empty or being accepted): the lowest set bit is extracted and cleared.
  - If pending is valid, pending moves to the output register with tlast=0; the new address then goes into pending.
  - If scan_word == 0: the next word loads directly into scan_word (one cycle per empty word), and the consumed stored word is cleared to 0.
  - After the last word is exhausted -> FLUSH.
- FLUSH:
  - If pending is valid, it moves to the output with tlast=1 when the slot is free or being accepted -> DONE.
  - If no spikes were found -> DONE directly, with no beat.
- DONE: waits for the tlast beat to be accepted (or proceeds at once for an empty frame), pulses o_frame_done, then -> IDLE.
- Handshake:
  - A beat transfers when tvalid && tready.
  - tdata/tlast are stable while tvalid && !tready.
  - tvalid never drops without acceptance.
- Throughput: one beat per cycle with tready=1.
- Latency bound: o_frame_done no later than NUM_WORDS + nspikes + 4 cycles after start, with tready held high.
- Address order is strictly ascending.
- o_spike_count: cleared on an accepted start, incremented per accepted beat, held after done.
- Bitmap self-clears during the scan, so the next frame starts empty.
- Reset mid-frame: immediate return to IDLE. The bitmap is cleared and the output beat is abandoned (tvalid=0).

Optional Feature:
- Macro: SPIKE_TX_EMPTY_BEAT_EN.
- Defined: an empty frame emits one sentinel beat, tdata = all ones and tlast=1, so the receiver still sees end-of-frame. o_spike_count = 1 for that frame.
- Undefined: an empty frame emits no beats; only the o_frame_done pulse, with count 0.

Decomposition:
- Package spike_tx_pkg:
  - FSM state encoding (IDLE, SCAN, FLUSH, DONE).
  - Sentinel address constant.
  - Derived NUM_WORDS/WADDR_WIDTH helper function.
- Sub-module lsb_priority_enc:
  - Input: WORD_WIDTH bits.
  - Outputs: lowest set-bit index, any-set flag, and the word with that bit cleared.

Test Plan (NUM_INPUTS=100, WORD_WIDTH=32, NUM_WORDS=4):
- Write word0=0x0000_0005, word2=0x8000_0000; start; tready=1 -> beats 0, 2, 95 in order; tlast only on 95; count=3; done pulse once; bitmap reads back all zero.
- Write word3=0xFFFF_FFFF -> only addresses 96..99 emitted (bits 4..31 masked); tlast on 99.
- Empty frame -> no beat, done pulse, count=0. With SPIKE_TX_EMPTY_BEAT_EN: one beat 0x3FFF with tlast=1, count=1.
- Three spikes with tready toggling 1,0,0,1,… -> tdata/tlast stable during stalls; no beat lost or duplicated; order ascending.
- Write and start in the same cycle (addr 1 bit 0) -> beat 32 included. Write during busy -> o_wr_drop pulses and the data is absent from the next frame. Second start while busy is ignored.
- Assert rst_n low mid-frame with tvalid high -> tvalid=0 immediately. After release, FSM is in IDLE and a new empty frame gives done with count=0.
